// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
// Shared types and constants for the stopwatch display path.
//   - BCD digit width and digit / digit-set types
//   - Digit index type (selects one of the four display positions)
//   - Display FSM state enum
//   - Active-low seven-segment patterns {g,f,e,d,c,b,a}
//   - Helper that turns a digit index into a one-hot-low anode vector
// -----------------------------------------------------------------------------
package stopwatch_pkg;

  localparam int BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_t;

  // Position 0 = seconds ones ... position 3 = minutes tens.
  typedef logic [3:0][BCD_W-1:0] digits_t;

  typedef logic [1:0] digit_idx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  localparam logic [3:0] AN_OFF   = 4'b1111;

  // Anodes are active-low, so the selected position is the single 0 bit.
  function automatic logic [3:0] an_select(input digit_idx_t idx);
    logic [3:0] a;
    a      = AN_OFF;
    a[idx] = 1'b0;
    return a;
  endfunction

endpackage

// File: rtl/stopwatch_display_mux_bcd_to_seg.sv
// -----------------------------------------------------------------------------
// bcd_to_seg
// Purely combinational BCD to active-low seven-segment decoder.
// Ports:
//   bcd  in  4  digit value; 0..9 decode to numerals, anything above 9 to a dash
//   seg  out 7  active-low segments {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module bcd_to_seg
  import stopwatch_pkg::*;
(
  input  logic [BCD_W-1:0] bcd,
  output logic [6:0]       seg
);

  // Codes 10..15 cannot come from a healthy counter, so they light only the
  // middle bar to make a corrupted digit obvious on the display.
  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/stopwatch_display_mux.sv
// -----------------------------------------------------------------------------
// stopwatch_display_mux
// Captures the four mm:ss BCD digits from the stopwatch counter and scans them
// onto a 4-digit common-anode multiplexed seven-segment display.
// Each digit is lit for DIGIT_CYCLES clocks followed by BLANK_CYCLES clocks with
// every anode off (anti-ghosting). Digits are captured into a shadow copy on
// load and only promoted to the displayed (active) copy at frame start, so a
// frame never mixes old and new digits.
// Ports:
//   clk                   in  1  system clock
//   rst                   in  1  synchronous active-high reset
//   enable                in  1  display on when high
//   load                  in  1  single-cycle strobe capturing the four digits
//   seconds_ones_counter  in  4  BCD 0..9
//   seconds_tens_counter  in  4  BCD 0..5
//   minutes_ones_counter  in  4  BCD 0..9
//   minutes_tens_counter  in  4  BCD 0..5
//   blank_lz              in  1  blank the minutes-tens digit when it is 0
//   an                    out 4  anodes, active-low; an[0] = seconds ones
//   seg                   out 7  segments {g,f,e,d,c,b,a}, active-low
//   dp                    out 1  decimal point, active-low (mm.ss separator)
//   frame_done            out 1  one-cycle pulse at the end of each frame
// -----------------------------------------------------------------------------
module stopwatch_display_mux
  import stopwatch_pkg::*;
#(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             load,
  input  logic [BCD_W-1:0] seconds_ones_counter,
  input  logic [BCD_W-1:0] seconds_tens_counter,
  input  logic [BCD_W-1:0] minutes_ones_counter,
  input  logic [BCD_W-1:0] minutes_tens_counter,
  input  logic             blank_lz,
  output logic [3:0]       an,
  output logic [6:0]       seg,
  output logic             dp,
  output logic             frame_done
);

  localparam int MAX_CYCLES = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state_q, state_d;
  digit_idx_t       index_q, index_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  digits_t          shadow_q, shadow_d;
  digits_t          active_q, active_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             frame_done_q, frame_done_d;

  digits_t          incoming;
  logic             frame_start;
  bcd_t             sel_digit;
  logic [6:0]       dec_seg;

  assign incoming = {minutes_tens_counter, minutes_ones_counter,
                     seconds_tens_counter, seconds_ones_counter};

  // Scan sequencer: IDLE waits for enable, SHOW holds one digit for
  // DIGIT_CYCLES, GAP blanks for BLANK_CYCLES and advances the index.
  // frame_start marks the two points where a new frame begins (leaving IDLE
  // and leaving the last gap); only there may the active digits change. A load
  // coinciding with frame start bypasses the shadow so the fresh value is not
  // delayed by a whole frame.
  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    cnt_d        = cnt_q;
    shadow_d     = load ? incoming : shadow_q;
    active_d     = active_q;
    frame_start  = 1'b0;
    frame_done_d = 1'b0;

    if (!enable) begin
      state_d = IDLE;
      index_d = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d     = SHOW;
          index_d     = '0;
          cnt_d       = '0;
          frame_start = 1'b1;
        end
        SHOW: begin
          if (cnt_q == DIGIT_LAST) begin
            state_d = GAP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        GAP: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = SHOW;
            index_d = index_q + 2'd1;
            cnt_d   = '0;
            if (index_q == 2'd3) begin
              frame_done_d = 1'b1;
              frame_start  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          index_d = '0;
          cnt_d   = '0;
        end
      endcase
    end

    if (frame_start) begin
      active_d = load ? incoming : shadow_q;
    end
  end

  assign sel_digit = active_q[index_q];

  bcd_to_seg u_bcd_to_seg (
    .bcd (sel_digit),
    .seg (dec_seg)
  );

  // Output register inputs, derived from the registered state so the pins
  // trail the sequencer by one clock. enable is also looked at directly so
  // the anodes go dark on the very edge that samples enable low, instead of
  // one digit slot late.
  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (enable && (state_q == SHOW)) begin
      an_d = an_select(index_q);
      if ((index_q == 2'd3) && blank_lz && (active_q[3] == '0)) begin
        seg_d = SEG_OFF;
      end else begin
        seg_d = dec_seg;
      end
      dp_d = (index_q != 2'd2);
    end
  end

  // All state and output flops; reset returns the display to dark and clears
  // both digit copies.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      index_q      <= '0;
      cnt_q        <= '0;
      shadow_q     <= '0;
      active_q     <= '0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_stopwatch_display_mux.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_display_mux
// Self-checking bench for stopwatch_display_mux with DIGIT_CYCLES=4 and
// BLANK_CYCLES=1, giving 5 clocks per digit slot and a 20-clock frame.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_stopwatch_display_mux;

  localparam int DIGIT_CYCLES = 4;
  localparam int BLANK_CYCLES = 1;
  localparam int SLOT         = DIGIT_CYCLES + BLANK_CYCLES;
  localparam int FRAME        = 4 * SLOT;

  localparam logic [6:0] S0   = 7'b1000000;
  localparam logic [6:0] S1   = 7'b1111001;
  localparam logic [6:0] S2   = 7'b0100100;
  localparam logic [6:0] S3   = 7'b0110000;
  localparam logic [6:0] S4   = 7'b0011001;
  localparam logic [6:0] S5   = 7'b0010010;
  localparam logic [6:0] S6   = 7'b0000010;
  localparam logic [6:0] S7   = 7'b1111000;
  localparam logic [6:0] S8   = 7'b0000000;
  localparam logic [6:0] S9   = 7'b0010000;
  localparam logic [6:0] DASH = 7'b0111111;
  localparam logic [6:0] OFF  = 7'b1111111;

  typedef struct {
    logic [3:0][3:0] digits;
    logic            blz;
    logic [3:0][6:0] segs;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       load;
  logic [3:0] seconds_ones_counter;
  logic [3:0] seconds_tens_counter;
  logic [3:0] minutes_ones_counter;
  logic [3:0] minutes_tens_counter;
  logic       blank_lz;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_done;

  int cmp_count  = 0;
  int mism_count = 0;

  vec_t vecs [5];

  stopwatch_display_mux #(
    .DIGIT_CYCLES (DIGIT_CYCLES),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .enable               (enable),
    .load                 (load),
    .seconds_ones_counter (seconds_ones_counter),
    .seconds_tens_counter (seconds_tens_counter),
    .minutes_ones_counter (minutes_ones_counter),
    .minutes_tens_counter (minutes_tens_counter),
    .blank_lz             (blank_lz),
    .an                   (an),
    .seg                  (seg),
    .dp                   (dp),
    .frame_done           (frame_done)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares all four outputs against one expected set and logs a mismatch.
  task automatic checkOutput(input string name, input logic [3:0] exp_an,
                             input logic [6:0] exp_seg, input logic exp_dp,
                             input logic exp_fd);
    cmp_count++;
    if ((an !== exp_an) || (seg !== exp_seg) || (dp !== exp_dp) || (frame_done !== exp_fd)) begin
      mism_count++;
      $display("[TB] FAIL %s: got an=%b seg=%b dp=%b fd=%b, expected an=%b seg=%b dp=%b fd=%b",
               name, an, seg, dp, frame_done, exp_an, exp_seg, exp_dp, exp_fd);
    end
  endtask

  // Advances to the next falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  // Runs n_slots clocks of a frame that should display exp_segs, checking
  // every clock. Slot p counts clocks after a frame boundary; each digit takes
  // 4 lit clocks then 1 dark clock, and frame_done accompanies the final gap.
  // If ld_p is in range, the digits ld_digits are strobed in so that the load
  // is sampled on the same edge that produces slot ld_p.
  task automatic applyStimulus(input string tag, input logic [3:0][6:0] exp_segs,
                               input logic blz, input int ld_p,
                               input logic [3:0][3:0] ld_digits, input int n_slots);
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;
    int         d;
    int         w;
    blank_lz = blz;
    for (int p = 0; p < n_slots; p++) begin
      if (p == ld_p) begin
        load                 = 1'b1;
        seconds_ones_counter = ld_digits[0];
        seconds_tens_counter = ld_digits[1];
        minutes_ones_counter = ld_digits[2];
        minutes_tens_counter = ld_digits[3];
      end
      tick();
      load = 1'b0;
      d = p / SLOT;
      w = p % SLOT;
      exp_an  = 4'b1111;
      exp_seg = OFF;
      exp_dp  = 1'b1;
      if (w < DIGIT_CYCLES) begin
        exp_an[d] = 1'b0;
        exp_seg   = exp_segs[d];
        exp_dp    = (d == 2) ? 1'b0 : 1'b1;
      end
      checkOutput($sformatf("%s p%0d", tag, p), exp_an, exp_seg, exp_dp, (p == FRAME - 1));
    end
  endtask

  initial begin
    logic [3:0][6:0] prev_segs;
    logic            prev_blz;
    logic [3:0][3:0] no_digits;

    vecs[0] = '{digits: {4'd1, 4'd2, 4'd3, 4'd4}, blz: 1'b0, segs: {S1, S2, S3, S4}};
    vecs[1] = '{digits: {4'd0, 4'd9, 4'd5, 4'd0}, blz: 1'b1, segs: {OFF, S9, S5, S0}};
    vecs[2] = '{digits: {4'd8, 4'd6, 4'd7, 4'hC}, blz: 1'b1, segs: {S8, S6, S7, DASH}};
    vecs[3] = '{digits: {4'hF, 4'd0, 4'd0, 4'd0}, blz: 1'b1, segs: {DASH, S0, S0, S0}};
    vecs[4] = '{digits: {4'd0, 4'hA, 4'hB, 4'd1}, blz: 1'b1, segs: {OFF, DASH, DASH, S1}};

    no_digits = '0;

    rst                  = 1'b1;
    enable               = 1'b1;
    load                 = 1'b0;
    blank_lz             = 1'b0;
    seconds_ones_counter = '0;
    seconds_tens_counter = '0;
    minutes_ones_counter = '0;
    minutes_tens_counter = '0;

    $display("[TB] reset held with enable high");
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("reset c%0d", i), 4'b1111, OFF, 1'b1, 1'b0);
    end

    rst = 1'b0;
    tick();
    checkOutput("release edge", 4'b1111, OFF, 1'b1, 1'b0);

    $display("[TB] decode vectors");
    prev_segs = {S0, S0, S0, S0};
    prev_blz  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus($sformatf("vec%0d pre", i), prev_segs, prev_blz, 10, vecs[i].digits, FRAME);
      applyStimulus($sformatf("vec%0d", i), vecs[i].segs, vecs[i].blz, -1, no_digits, FRAME);
      prev_segs = vecs[i].segs;
      prev_blz  = vecs[i].blz;
    end

    $display("[TB] tear-free update");
    applyStimulus("tf setup", prev_segs, prev_blz, 10, {4'd1, 4'd2, 4'd3, 4'd4}, FRAME);
    applyStimulus("tf old", {S1, S2, S3, S4}, 1'b1, 6, {4'd0, 4'd5, 4'd5, 4'd9}, FRAME);
    applyStimulus("tf new lz", {OFF, S5, S5, S9}, 1'b1, -1, no_digits, FRAME);

    $display("[TB] load on frame boundary");
    applyStimulus("tf new nolz", {S0, S5, S5, S9}, 1'b0, FRAME - 1, {4'd0, 4'd7, 4'd0, 4'd8}, FRAME);
    applyStimulus("bypass", {S0, S7, S0, S8}, 1'b0, -1, no_digits, FRAME);

    $display("[TB] enable drop during minutes ones");
    applyStimulus("pre drop", {S0, S7, S0, S8}, 1'b0, -1, no_digits, 2 * SLOT + 2);
    enable = 1'b0;
    tick();
    checkOutput("enable drop", 4'b1111, OFF, 1'b1, 1'b0);
    tick();
    checkOutput("disabled", 4'b1111, OFF, 1'b1, 1'b0);
    enable = 1'b1;
    tick();
    checkOutput("re-enable edge", 4'b1111, OFF, 1'b1, 1'b0);
    applyStimulus("restart", {S0, S7, S0, S8}, 1'b0, -1, no_digits, FRAME);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, mism_count);
    $finish;
  end

endmodule

// File: doc/stopwatch_display_mux.md
Name: stopwatch_display_mux

Overview:
- Consumer end of the stopwatch counter's digit interface.
- Captures the four BCD digit counts (mm:ss) and drives a 4-digit, common-anode, multiplexed seven-segment display.
- Provides an anti-ghosting blank gap, optional leading-zero blanking, a fixed minutes/seconds separator dot, and tear-free frame updates.

Parameters:
- DIGIT_CYCLES, 100000, clocks each digit is lit (1 ms at 100 MHz); must be >= 1.
- BLANK_CYCLES, 16, clocks all anodes are off between digits; must be >= 1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  display on when high
- load  in  1  single-cycle strobe; capture the four digit inputs
- seconds_ones_counter  in  4  BCD 0..9
- seconds_tens_counter  in  4  BCD 0..5
- minutes_ones_counter  in  4  BCD 0..9
- minutes_tens_counter  in  4  BCD 0..5
- blank_lz  in  1  blank minutes-tens digit when it is 0
- an  out  4  anodes, active-low; an[0] = seconds ones, an[3] = minutes tens
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low
- frame_done  out  1  one-cycle pulse at the end of each 4-digit frame

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - an=4'b1111, seg=7'b1111111, dp=1, frame_done=0.
  - state=IDLE, digit index=0, cycle counter=0.
  - Shadow and active digit registers all 0.
- Outputs are registered. an/seg/dp reflect the state and index one cycle after they change.
- Shadow capture: on load=1, shadow <= the four inputs. Without load, shadow holds.
- Active copy:
  - active <= shadow only at frame start (entering SHOW with index 0).
  - If load is high in that same cycle, active takes the incoming inputs (bypass).
  - Result: a frame never mixes old and new digits.
- FSM:
  - IDLE: all anodes off. Go to SHOW with index 0 when enable=1; perform the active copy on that transition.
  - SHOW: an = one-hot-low of index; seg = decode(active[index]). Stay DIGIT_CYCLES cycles, then go to GAP.
  - GAP: an=4'b1111, seg=7'b1111111, dp=1. Stay BLANK_CYCLES cycles. Then index <= index+1 (wraps 3->0) and go to SHOW.
  - On the GAP exit where index==3: pulse frame_done for one cycle and perform the active copy.
- enable=0 in any state: next state IDLE, index and counter cleared. an goes to 4'b1111 on the following registered edge. rst behaves the same way and additionally clears shadow and active.
- Cycle counter: width $clog2(max(DIGIT_CYCLES, BLANK_CYCLES)+1). It cleared on every state change.
- Decode (active-low {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Any value >9: dash, 0111111 (segment g only).
  - Tens digits of 6..9 decode normally; no range check beyond 9.
- Leading-zero blanking: blank_lz=1 and active minutes_tens==0 -> seg=7'b1111111 during index 3. The anode still cycles normally.
- dp: 0 during SHOW of index 2 (minutes ones, the mm.ss separator); 1 otherwise.
- Frame period: 4*(DIGIT_CYCLES+BLANK_CYCLES) cycles.

Decomposition:
- Shared package stopwatch_pkg:
  - Segment constants SEG_0..SEG_9, SEG_DASH, SEG_OFF.
  - Digit index type (2 bits).
  - FSM state enum IDLE/SHOW/GAP.
  - BCD digit width constant (4).
- One combinational sub-module bcd_to_seg: 4-bit in, 7-bit active-low out, implementing the decode above.

Test Plan (DIGIT_CYCLES=4, BLANK_CYCLES=1):
1. Reset: rst=1 for 3 cycles with enable=1 -> an=1111, seg=1111111, dp=1, frame_done=0 throughout. After release: first SHOW has an=1110 within 2 cycles.
2. Static 12:34: load once, enable=1 -> an=1110/seg=0011001 (4) for 4 cycles, gap 1111 for 1, then 1101/0110000 (3), 1011/0100100 (2) with dp=0, 0111/1111001 (1). frame_done pulses every 20 cycles.
3. Tear-free update: load 05:59 mid-frame at index 1 -> remainder of frame still shows 12:34; next frame shows 9,5,5 and blank digit 3 (blank_lz=1). With blank_lz=0, digit 3 shows 1000000.
4. Simultaneous: load 07:08 in the exact cycle of the frame boundary -> first digit of the new frame is 8 (0000000), not the old value.
5. Invalid digit: seconds_ones_counter=4'hC -> digit 0 shows 0111111 (dash).
6. enable drop mid-SHOW at index 2 -> an=1111 on the next edge, dp=1. Re-enable -> restarts at index 0 with an=1110.
